// File: rtl/loop_nest_counter.sv
// loop_nest_counter
//   Stallable, multi-dimensional loop-nest iteration generator. It sits
//   between the schedule controller and the datapath/SRAM address generators.
//   A start in IDLE latches the run-time trip counts. One iteration is then
//   issued at most every II clocks, in odometer order with dim 0 innermost.
//   Each issue presents the full index vector. The final issue is flagged
//   with last, and done pulses once when the nest is complete.
//
// Parameters
//   DIMS  number of loop dimensions (dim 0 varies fastest)
//   W     width of each trip count and index (unsigned)
//   II    minimum clocks between issues, >= 1
//
// Ports
//   clk    clock, all state updates on posedge
//   rst    synchronous, active-high reset
//   start  one-cycle request to begin a nest, honoured only in IDLE
//   trip   trip counts, dim d at [d*W +: W], sampled on an accepted start
//   stall  downstream not ready; blocks issue but not the II gap countdown
//   valid  an iteration is issued this cycle
//   idx    index vector of the current iteration, dim d at [d*W +: W]
//   last   valid on the final iteration of the nest
//   busy   a nest is in progress
//   done   one-cycle pulse after the final issue or after a zero-trip start

module loop_nest_counter #(
  parameter int DIMS = 2,
  parameter int W    = 16,
  parameter int II   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DIMS*W-1:0] trip,
  input  logic              stall,
  output logic              valid,
  output logic [DIMS*W-1:0] idx,
  output logic              last,
  output logic              busy,
  output logic              done
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // The gap counter only ever holds values up to II-1.
  localparam int            GW         = (II > 1) ? $clog2(II) : 1;
  localparam logic [GW-1:0] GAP_RELOAD = GW'(II - 1);

  logic [0:0]        state_q, state_d;
  logic [DIMS*W-1:0] idx_q, idx_d;
  logic [DIMS*W-1:0] trip_q, trip_d;
  logic [GW-1:0]     gap_q, gap_d;
  logic              done_q, done_d;

  logic [DIMS-1:0]   at_end;
  logic              all_end;
  logic              trip_zero;
  logic [DIMS*W-1:0] idx_next;

  // Per-dimension wrap flags against the latched trips, and a zero-trip test
  // on the live trip input so that a start can be rejected before latching.
  always_comb begin
    at_end    = '0;
    trip_zero = 1'b0;
    for (int d = 0; d < DIMS; d++) begin
      at_end[d] = (idx_q[d*W +: W] == (trip_q[d*W +: W] - W'(1)));
      if (trip[d*W +: W] == '0) begin
        trip_zero = 1'b1;
      end
    end
    all_end = &at_end;
  end

  // Odometer increment: a dimension that sits at trip-1 wraps to zero and
  // passes the carry upward. The first dimension that does not wrap absorbs it.
  always_comb begin
    logic carry;
    idx_next = idx_q;
    carry    = 1'b1;
    for (int d = 0; d < DIMS; d++) begin
      if (carry) begin
        if (at_end[d]) begin
          idx_next[d*W +: W] = '0;
        end else begin
          idx_next[d*W +: W] = idx_q[d*W +: W] + W'(1);
          carry              = 1'b0;
        end
      end
    end
  end

  assign valid = (state_q == ST_RUN) && (gap_q == '0) && !stall;
  assign last  = valid && all_end;
  assign busy  = (state_q == ST_RUN);
  assign done  = done_q;
  assign idx   = idx_q;

  // Next-state logic. The gap counter runs down on its own, independent of
  // stall, so a stall during the gap does not stretch the II spacing. Only a
  // stall at gap==0 delays an issue.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    trip_d  = trip_q;
    gap_d   = (gap_q != '0) ? gap_q - GW'(1) : gap_q;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (trip_zero) begin
            done_d = 1'b1;
          end else begin
            trip_d  = trip;
            idx_d   = '0;
            gap_d   = '0;
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (valid) begin
          if (all_end) begin
            state_d = ST_IDLE;
            idx_d   = '0;
            gap_d   = '0;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_next;
            gap_d = GAP_RELOAD;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      trip_q  <= '0;
      gap_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      trip_q  <= trip_d;
      gap_q   <= gap_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_loop_nest_counter.sv
// tb_loop_nest_counter
//   Directed bench for loop_nest_counter with DIMS=2, W=8. Instance u_a uses
//   II=1 and instance u_b uses II=3. They share the clock and reset. Every
//   expected value is written out by hand for the directed sequences.

module tb_loop_nest_counter;

  logic        clk;
  logic        rst;

  logic        start_a, stall_a;
  logic [15:0] trip_a;
  logic        valid_a, last_a, busy_a, done_a;
  logic [15:0] idx_a;

  logic        start_b, stall_b;
  logic [15:0] trip_b;
  logic        valid_b, last_b, busy_b, done_b;
  logic [15:0] idx_b;

  int checks;
  int errors;

  loop_nest_counter #(.DIMS(2), .W(8), .II(1)) u_a (
    .clk   (clk),
    .rst   (rst),
    .start (start_a),
    .trip  (trip_a),
    .stall (stall_a),
    .valid (valid_a),
    .idx   (idx_a),
    .last  (last_a),
    .busy  (busy_a),
    .done  (done_a)
  );

  loop_nest_counter #(.DIMS(2), .W(8), .II(3)) u_b (
    .clk   (clk),
    .rst   (rst),
    .start (start_b),
    .trip  (trip_b),
    .stall (stall_b),
    .valid (valid_b),
    .idx   (idx_b),
    .last  (last_b),
    .busy  (busy_b),
    .done  (done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Move to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one instance's inputs for the current cycle, then let the
  // combinational outputs settle.
  task automatic apply_stimulus(input bit sel, input logic s, input logic [7:0] t0,
                                input logic [7:0] t1, input logic st);
    if (sel == 1'b0) begin
      start_a = s;
      trip_a  = {t1, t0};
      stall_a = st;
    end else begin
      start_b = s;
      trip_b  = {t1, t0};
      stall_b = st;
    end
    #1;
  endtask

  task automatic check(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic check_output(input string tag, input bit sel, input logic ev, input logic el,
                              input logic eb, input logic ed, input bit chk_idx,
                              input int e0, input int e1);
    logic        v, l, b, d;
    logic [15:0] ix;
    v  = sel ? valid_b : valid_a;
    l  = sel ? last_b  : last_a;
    b  = sel ? busy_b  : busy_a;
    d  = sel ? done_b  : done_a;
    ix = sel ? idx_b   : idx_a;
    check({tag, ".valid"}, int'(v), int'(ev));
    check({tag, ".last"},  int'(l), int'(el));
    check({tag, ".busy"},  int'(b), int'(eb));
    check({tag, ".done"},  int'(d), int'(ed));
    if (chk_idx) begin
      check({tag, ".idx0"}, int'(ix[7:0]),  e0);
      check({tag, ".idx1"}, int'(ix[15:8]), e1);
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    rst     = 1'b1;
    start_a = 1'b0; trip_a = '0; stall_a = 1'b0;
    start_b = 1'b0; trip_b = '0; stall_b = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_output("reset_a", 1'b0, 0, 0, 0, 0, 1, 0, 0);
    check_output("reset_b", 1'b1, 0, 0, 0, 0, 1, 0, 0);
    rst = 1'b0;
    tick();

    // Basic 3x2 nest at II=1.
    $display("[TB] basic nest trip=(3,2) II=1");
    apply_stimulus(1'b0, 1'b1, 8'd3, 8'd2, 1'b0);
    check_output("t1_start", 1'b0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    for (int i = 0; i < 6; i++) begin
      apply_stimulus(1'b0, 1'b0, 8'd3, 8'd2, 1'b0);
      check_output($sformatf("t1_iter%0d", i), 1'b0, 1, (i == 5), 1, 0, 1, i % 3, i / 3);
      tick();
    end
    apply_stimulus(1'b0, 1'b0, 8'd3, 8'd2, 1'b0);
    check_output("t1_done", 1'b0, 0, 0, 0, 1, 0, 0, 0);
    tick();
    check_output("t1_after", 1'b0, 0, 0, 0, 0, 0, 0, 0);
    tick();

    // II=3 spacing with trip=(2,2): issues on cycles 1,4,7,10 after start.
    $display("[TB] II=3 nest trip=(2,2)");
    apply_stimulus(1'b1, 1'b1, 8'd2, 8'd2, 1'b0);
    tick();
    for (int c = 1; c <= 10; c++) begin
      bit ev;
      int k;
      ev = ((c - 1) % 3 == 0);
      k  = (c - 1) / 3;
      apply_stimulus(1'b1, 1'b0, 8'd2, 8'd2, 1'b0);
      check_output($sformatf("t2_c%0d", c), 1'b1, ev, ev && (k == 3), 1, 0, ev, k % 2, k / 2);
      tick();
    end
    apply_stimulus(1'b1, 1'b0, 8'd2, 8'd2, 1'b0);
    check_output("t2_done", 1'b1, 0, 0, 0, 1, 0, 0, 0);
    tick();

    // Stall on cycles 2-4 after start, trip=(4,1), II=1. idx must hold at 1.
    $display("[TB] stall hold trip=(4,1) II=1");
    apply_stimulus(1'b0, 1'b1, 8'd4, 8'd1, 1'b0);
    tick();
    for (int c = 1; c <= 7; c++) begin
      bit st;
      int k;
      st = (c >= 2) && (c <= 4);
      k  = (c == 1) ? 0 : ((c <= 4) ? 1 : c - 4);
      apply_stimulus(1'b0, 1'b0, 8'd4, 8'd1, st);
      check_output($sformatf("t3_c%0d", c), 1'b0, !st, (c == 7), 1, 0, 1, k, 0);
      tick();
    end
    apply_stimulus(1'b0, 1'b0, 8'd4, 8'd1, 1'b0);
    check_output("t3_done", 1'b0, 0, 0, 0, 1, 0, 0, 0);
    tick();

    // A one-cycle stall in the gap after an issue must not delay the next issue at II=3.
    $display("[TB] stall in gap trip=(3,1) II=3");
    apply_stimulus(1'b1, 1'b1, 8'd3, 8'd1, 1'b0);
    tick();
    for (int c = 1; c <= 7; c++) begin
      bit ev;
      ev = (c == 1) || (c == 4) || (c == 7);
      apply_stimulus(1'b1, 1'b0, 8'd3, 8'd1, (c == 2));
      check_output($sformatf("t4_c%0d", c), 1'b1, ev, (c == 7), 1, 0, ev, (c - 1) / 3, 0);
      tick();
    end
    apply_stimulus(1'b1, 1'b0, 8'd3, 8'd1, 1'b0);
    check_output("t4_done", 1'b1, 0, 0, 0, 1, 0, 0, 0);
    tick();

    // A zero trip in dim 1 gives no issues and an immediate done.
    $display("[TB] zero trip (5,0)");
    apply_stimulus(1'b0, 1'b1, 8'd5, 8'd0, 1'b0);
    check_output("t5_start", 1'b0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    apply_stimulus(1'b0, 1'b0, 8'd5, 8'd0, 1'b0);
    check_output("t5_done", 1'b0, 0, 0, 0, 1, 0, 0, 0);
    tick();
    check_output("t5_after", 1'b0, 0, 0, 0, 0, 0, 0, 0);
    tick();

    // Reset asserted on the 3rd issue aborts the nest without a done pulse.
    $display("[TB] reset mid-nest");
    apply_stimulus(1'b0, 1'b1, 8'd3, 8'd2, 1'b0);
    tick();
    for (int c = 1; c <= 3; c++) begin
      apply_stimulus(1'b0, 1'b0, 8'd3, 8'd2, 1'b0);
      if (c == 3) rst = 1'b1;
      check_output($sformatf("t6_c%0d", c), 1'b0, 1, 0, 1, 0, 1, c - 1, 0);
      tick();
    end
    rst = 1'b0;
    apply_stimulus(1'b0, 1'b0, 8'd3, 8'd2, 1'b0);
    check_output("t6_abort", 1'b0, 0, 0, 0, 0, 1, 0, 0);
    tick();
    check_output("t6_nodone", 1'b0, 0, 0, 0, 0, 0, 0, 0);
    tick();

    // Start during RUN is ignored. Trip is left at (9,9) for the rest of the nest.
    $display("[TB] start ignored in RUN, then back-to-back nest");
    apply_stimulus(1'b0, 1'b1, 8'd3, 8'd2, 1'b0);
    tick();
    for (int i = 0; i < 6; i++) begin
      if (i == 1) apply_stimulus(1'b0, 1'b1, 8'd9, 8'd9, 1'b0);
      else        apply_stimulus(1'b0, 1'b0, 8'd9, 8'd9, 1'b0);
      check_output($sformatf("t7_iter%0d", i), 1'b0, 1, (i == 5), 1, 0, 1, i % 3, i / 3);
      tick();
    end
    // A start in the done cycle is accepted with the new trips (2,1).
    apply_stimulus(1'b0, 1'b1, 8'd2, 8'd1, 1'b0);
    check_output("t8_donestart", 1'b0, 0, 0, 0, 1, 0, 0, 0);
    tick();
    for (int i = 0; i < 2; i++) begin
      apply_stimulus(1'b0, 1'b0, 8'd2, 8'd1, 1'b0);
      check_output($sformatf("t8_iter%0d", i), 1'b0, 1, (i == 1), 1, 0, 1, i, 0);
      tick();
    end
    apply_stimulus(1'b0, 1'b0, 8'd2, 8'd1, 1'b0);
    check_output("t8_done", 1'b0, 0, 0, 0, 1, 0, 0, 0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
